// File: rtl/wbwide_linebuf_pkg.sv
// rtl/wbwide_linebuf_pkg.sv - shared wide-bus constants and request record
package wbwide_linebuf_pkg;

    // Byte address width of the small-side bus and the wide data width
    localparam int WB_BYTE_AW = 28;
    localparam int WB_DW      = 512;

    // Wide-word address width: byte address less the byte-within-word bits
    localparam int WB_AW      = WB_BYTE_AW - $clog2(WB_DW / 8);

    // One outstanding downstream request as held in the request FIFO
    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] addr;
    } wb_req_t;

endpackage

// File: rtl/sfifo.sv
// rtl/sfifo.sv - synchronous first-word-fall-through FIFO with fill count
module sfifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_fill
);

    localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};

    logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0] wr_ptr, rd_ptr;
    logic            do_wr, do_rd;

    assign o_fill  = wr_ptr - rd_ptr;
    assign o_empty = (wr_ptr == rd_ptr);
    assign do_rd   = i_rd && !o_empty;
    assign do_wr   = i_wr && ((o_fill != DEPTH) || do_rd);
    assign o_data  = mem[rd_ptr[LGFLEN-1:0]];

    // Pointer update; reset doubles as a flush
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (do_wr)
            mem[wr_ptr[LGFLEN-1:0]] <= i_data;
    end

endmodule

// File: rtl/wbwide_linebuf.sv
// rtl/wbwide_linebuf.sv - single-line read buffer on the wide Wishbone bus
module wbwide_linebuf
    import wbwide_linebuf_pkg::*;
#(
    parameter int AW           = WB_AW,
    parameter int DW           = WB_DW,
    parameter int LGFIFO       = 4,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sstall,
    output logic            o_sack,
    output logic            o_serr,
    output logic [DW-1:0]   o_sdata,
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic [DW-1:0]   i_mdata
);

    localparam logic [LGFIFO:0] FIFO_DEPTH = {1'b1, {LGFIFO{1'b0}}};

    logic            line_valid;
    logic [AW-1:0]   line_tag;
    logic [DW-1:0]   line_data;
    logic [LGFIFO:0] nwr;

    logic            fifo_empty;
    logic [LGFIFO:0] fifo_fill;
    logic [AW:0]     fifo_rdata;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;

    logic busy, slots_full, accept, hit, forward, m_accept;
    logic abort, ack_valid, err_valid, flush, fill, wr_inval;

    assign {rd_we, rd_addr} = fifo_rdata;

    // A request sitting in the strobe register already owns a FIFO slot, so
    // it is counted here; otherwise a full FIFO could lose an accepted strobe.
    assign slots_full = (fifo_fill + {{LGFIFO{1'b0}}, o_mstb}) >= FIFO_DEPTH;
    assign busy       = o_mstb || !fifo_empty;
    assign o_sstall   = (o_mstb && i_mstall) || slots_full;

    assign accept    = i_scyc && i_sstb && !o_sstall;
    assign hit       = accept && !i_swe && line_valid && (i_saddr == line_tag) && !busy;
    assign forward   = accept && !hit;
    assign m_accept  = o_mstb && !i_mstall;

    assign abort     = !i_scyc;
    assign err_valid = i_scyc && o_mcyc && i_merr;
    assign ack_valid = i_scyc && o_mcyc && i_mack && !i_merr && !fifo_empty;
    assign flush     = abort || err_valid;

    // A write still waiting in the strobe register has not reached memory,
    // so a read returning now may carry pre-write data: do not cache it.
    assign fill      = ack_valid && !rd_we && (nwr == '0) && !(o_mstb && o_mwe);
    assign wr_inval  = forward && i_swe && (i_saddr == (fill ? rd_addr : line_tag));

    sfifo #(
        .BW     (AW + 1),
        .LGFLEN (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset || flush),
        .i_wr    (m_accept),
        .i_data  ({o_mwe, o_maddr}),
        .i_rd    (ack_valid),
        .o_data  (fifo_rdata),
        .o_empty (fifo_empty),
        .o_fill  (fifo_fill)
    );

    // Line tag and valid: fill on a clean read return, drop on write/error/abandoned write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            line_valid <= 1'b0;
            line_tag   <= '0;
        end else begin
            if (fill) begin
                line_valid <= 1'b1;
                line_tag   <= rd_addr;
            end
            if (err_valid || (abort && (nwr != '0)) || wr_inval)
                line_valid <= 1'b0;
        end
    end

    // Line data is only ever observed while line_valid is set
    always_ff @(posedge i_clk) begin
        if (fill)
            line_data <= i_mdata;
    end

    // Outstanding downstream write count
    always_ff @(posedge i_clk) begin
        if (i_reset || flush)
            nwr <= '0;
        else begin
            case ({m_accept && o_mwe, ack_valid && rd_we})
                2'b10:   nwr <= nwr + 1'b1;
                2'b01:   nwr <= nwr - 1'b1;
                default: nwr <= nwr;
            endcase
        end
    end

    // Downstream request register: cycle, strobe and payload
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            o_mwe   <= 1'b0;
            o_maddr <= '0;
            o_mdata <= '0;
            o_msel  <= '0;
        end else begin
            if (flush) begin
                o_mcyc <= 1'b0;
                o_mstb <= 1'b0;
            end else if (forward) begin
                o_mcyc <= 1'b1;
                o_mstb <= 1'b1;
            end else if (m_accept) begin
                o_mstb <= 1'b0;
            end

            if (forward && !flush) begin
                o_mwe   <= i_swe;
                o_maddr <= i_saddr;
                o_mdata <= i_sdata;
                o_msel  <= i_ssel;
            end else if (OPT_LOWPOWER && (flush || m_accept)) begin
                o_mwe   <= 1'b0;
                o_maddr <= '0;
                o_mdata <= '0;
                o_msel  <= '0;
            end
        end
    end

    // Upstream response: local hit, passed-through ack, or bus error
    always_ff @(posedge i_clk) begin
        if (i_reset || abort) begin
            o_sack <= 1'b0;
            o_serr <= 1'b0;
        end else begin
            o_sack <= hit || ack_valid;
            o_serr <= err_valid;
        end
    end

    // Upstream return data
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_sdata <= '0;
        else if (hit)
            o_sdata <= line_data;
        else if (ack_valid)
            o_sdata <= (OPT_LOWPOWER && rd_we) ? '0 : i_mdata;
        else if (OPT_LOWPOWER)
            o_sdata <= '0;
    end

endmodule

// File: tb/tb_wbwide_linebuf.sv
// tb/tb_wbwide_linebuf.sv - directed self-checking bench for wbwide_linebuf
module tb_wbwide_linebuf;

    localparam int AW = 22;
    localparam int DW = 512;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_scyc = 1'b0, i_sstb = 1'b0, i_swe = 1'b0;
    logic [AW-1:0]   i_saddr = '0;
    logic [DW-1:0]   i_sdata = '0;
    logic [DW/8-1:0] i_ssel = '1;
    logic            o_sstall, o_sack, o_serr;
    logic [DW-1:0]   o_sdata;
    logic            o_mcyc, o_mstb, o_mwe;
    logic [AW-1:0]   o_maddr;
    logic [DW-1:0]   o_mdata;
    logic [DW/8-1:0] o_msel;
    logic            i_mstall = 1'b0, i_mack = 1'b0, i_merr = 1'b0;
    logic [DW-1:0]   i_mdata = '0;

    wbwide_linebuf #(.AW(AW), .DW(DW), .LGFIFO(4), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
        .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
        .o_sstall(o_sstall), .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
        .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
        .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
        .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Downstream memory model
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } mreq_t;

    mreq_t         mq[$];
    logic [DW-1:0] mem [int];
    int            stall_cnt = 0;
    int            err_on    = -1;
    int            ack_cnt   = 0;
    int            n_req     = 0;
    int            acc_cyc   = 0;
    int            merr_cyc  = 0;
    bit            ack_block = 1'b0;

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        if (mem.exists(int'(a)))
            return mem[int'(a)];
        return {16{32'hD000_0000 | {10'd0, a}}};
    endfunction

    always @(negedge i_clk) begin : slave
        mreq_t r;
        i_mack   = 1'b0;
        i_merr   = 1'b0;
        i_mdata  = '0;
        i_mstall = (stall_cnt > 0);
        if (o_mstb && i_mstall)
            stall_cnt--;
        if (o_mstb && !i_mstall) begin
            n_req++;
            acc_cyc = cyc;
            r.we   = o_mwe;
            r.addr = o_maddr;
            r.due  = cyc + 3;
            if (o_mwe) begin
                mem[int'(o_maddr)] = o_mdata;
                r.data = '0;
            end else begin
                r.data = rd_mem(o_maddr);
            end
            mq.push_back(r);
        end
        if (!ack_block && mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            ack_cnt++;
            if (ack_cnt == err_on) begin
                i_merr   = 1'b1;
                merr_cyc = cyc;
            end else begin
                i_mack  = 1'b1;
                i_mdata = r.data;
            end
        end
    end

    // Upstream response monitor
    logic [DW-1:0] rxq[$];
    int            serr_cnt = 0;
    int            serr_cyc = 0;
    int            sack_cyc = 0;

    always @(negedge i_clk) begin
        if (o_sack) begin
            rxq.push_back(o_sdata);
            sack_cyc = cyc;
        end
        if (o_serr) begin
            serr_cnt++;
            serr_cyc = cyc;
        end
    end

    // Present one request from a negedge and return at the negedge after acceptance
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        i_sstb  = 1'b1;
        i_swe   = we;
        i_saddr = a;
        i_sdata = d;
        #1;
        while (o_sstall && t < 200) begin
            @(negedge i_clk);
            #1;
            t++;
        end
        if (t >= 200)
            check("stall_timeout", 1'b1, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_sstb = 1'b0;
        i_swe  = 1'b0;
    endtask

    task automatic wait_acks(input int n);
        int t = 0;
        while (rxq.size() < n && t < 300) begin
            @(negedge i_clk);
            #1;
            t++;
        end
        if (t >= 300)
            check("ack_timeout", rxq.size(), n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            @(negedge i_clk);
    endtask

    localparam logic [DW-1:0] DA    = {16{32'hA0A0_0010}};
    localparam logic [DW-1:0] DB    = {16{32'hB0B0_0010}};
    localparam logic [DW-1:0] DC    = {16{32'hC0C0_0030}};
    localparam logic [DW-1:0] OLD20 = {16{32'h0202_0000}};
    localparam logic [DW-1:0] W20   = {16{32'h2020_2020}};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base, nbase, ebase;
        mem[32'h10] = DA;
        mem[32'h20] = OLD20;
        mem[32'h30] = DC;

        idle(3);
        i_reset = 1'b0;
        i_scyc  = 1'b1;
        #1;
        check("rst_mcyc",  o_mcyc, 1'b0);
        check("rst_mstb",  o_mstb, 1'b0);
        check("rst_sack",  o_sack, 1'b0);
        check("rst_serr",  o_serr, 1'b0);
        check("rst_sdata", o_sdata, '0);
        check("rst_maddr", o_maddr, '0);
        check("rst_valid", dut.line_valid, 1'b0);
        check("rst_nwr",   dut.nwr, '0);
        check("rst_stall", o_sstall, 1'b0);
        @(negedge i_clk);

        // Cold read then local hit
        base = rxq.size(); nbase = n_req;
        issue(1'b0, 22'h10, '0);
        wait_acks(base + 1);
        check("cold_data",    rxq[base], DA);
        check("cold_nreq",    n_req - nbase, 1);
        check("cold_latency", sack_cyc - acc_cyc, 4);
        check("cold_valid",   dut.line_valid, 1'b1);
        check("cold_tag",     dut.line_tag, 22'h10);
        idle(2);
        issue(1'b0, 22'h10, '0);
        #1;
        check("hit_sack",  o_sack, 1'b1);
        check("hit_sdata", o_sdata, DA);
        check("hit_nreq",  n_req - nbase, 1);
        @(negedge i_clk);

        // Write invalidates, reread goes downstream
        base = rxq.size(); nbase = n_req;
        issue(1'b1, 22'h10, DB);
        #1;
        check("wr_inval", dut.line_valid, 1'b0);
        wait_acks(base + 1);
        idle(1);
        issue(1'b0, 22'h10, '0);
        wait_acks(base + 2);
        check("wr_reread", rxq[base + 1], DB);
        check("wr_nreq",   n_req - nbase, 2);
        idle(2);

        // Read with a write to the same word behind it: no fill
        base = rxq.size(); nbase = n_req;
        issue(1'b0, 22'h20, '0);
        issue(1'b1, 22'h20, W20);
        wait_acks(base + 2);
        idle(1);
        check("nf_data",  rxq[base], OLD20);
        check("nf_tag",   dut.line_tag, 22'h10);
        check("nf_valid", dut.line_valid, 1'b1);
        check("nf_nwr",   dut.nwr, '0);
        issue(1'b0, 22'h20, '0);
        wait_acks(base + 3);
        check("nf_reread", rxq[base + 2], W20);
        check("nf_nreq",   n_req - nbase, 3);
        idle(2);

        // Burst of 16 misses, downstream stalls then withholds acks
        base = rxq.size(); nbase = n_req;
        ack_block = 1'b1;
        stall_cnt = 5;
        for (int i = 0; i < 16; i++)
            issue(1'b0, 22'h100 + 22'(i), '0);
        idle(3);
        #1;
        check("full_stall", o_sstall, 1'b1);
        check("full_fill",  dut.fifo_fill, 5'd16);
        check("full_mstb",  o_mstb, 1'b0);
        check("full_nreq",  n_req - nbase, 16);
        ack_block = 1'b0;
        wait_acks(base + 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("burst_%0d", i), rxq[base + i], {16{32'hD000_0100 + 32'(i)}});
        idle(3);

        // Error on the second of three reads
        base = rxq.size(); ebase = serr_cnt;
        err_on = ack_cnt + 2;
        issue(1'b0, 22'h200, '0);
        issue(1'b0, 22'h201, '0);
        issue(1'b0, 22'h202, '0);
        idle(15);
        #1;
        check("err_acks",  rxq.size() - base, 1);
        check("err_data",  rxq[base], {16{32'hD000_0200}});
        check("err_count", serr_cnt - ebase, 1);
        check("err_delay", serr_cyc - merr_cyc, 1);
        check("err_mcyc",  o_mcyc, 1'b0);
        check("err_valid", dut.line_valid, 1'b0);
        err_on = -1;
        mq.delete();
        @(negedge i_clk);

        // Would-be hit behind an outstanding miss is forwarded and ordered
        base = rxq.size(); nbase = n_req;
        issue(1'b0, 22'h10, '0);
        wait_acks(base + 1);
        idle(2);
        issue(1'b0, 22'h30, '0);
        issue(1'b0, 22'h10, '0);
        wait_acks(base + 3);
        check("ord_nreq",  n_req - nbase, 3);
        check("ord_first", rxq[base + 1], DC);
        check("ord_second", rxq[base + 2], DB);
        idle(2);

        // Cycle abort with only a read outstanding keeps the line
        base = rxq.size(); nbase = n_req;
        ack_block = 1'b1;
        issue(1'b0, 22'h40, '0);
        i_scyc = 1'b0;
        @(negedge i_clk);
        i_scyc = 1'b1;
        #1;
        check("abt_mcyc",  o_mcyc, 1'b0);
        check("abt_mstb",  o_mstb, 1'b0);
        check("abt_empty", dut.fifo_empty, 1'b1);
        check("abt_valid", dut.line_valid, 1'b1);
        mq.delete();
        ack_block = 1'b0;
        @(negedge i_clk);
        nbase = n_req;
        issue(1'b0, 22'h10, '0);
        #1;
        check("abt_hit_sack", o_sack, 1'b1);
        check("abt_hit_data", o_sdata, DB);
        check("abt_hit_nreq", n_req - nbase, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
